reflet_bus_arbiter: RTL and testbench

REFLET_BUS_ARBITER -- requirements
Module: reflet_bus_arbiter

---
 rtl/reflet_bus_arbiter_pkg.sv | 33 +++
 rtl/reflet_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_reflet_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared encodings and helpers for the two-master bus arbiter.
// Holds the FSM state and read-return owner encodings.
package reflet_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN0   = 2'd1,
        SWITCH = 2'd2,
        OWN1   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } rd_owner_t;

    localparam logic [7:0] BURST_CNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == BURST_CNT_MAX) ? value : value + 8'd1;
    endfunction

    // The master whose read is in flight is simply whoever owns the bus now.
    function automatic rd_owner_t owner_of(input arb_state_t state);
        case (state)
            OWN0:    return M0;
            OWN1:    return M1;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/reflet_bus_arbiter.sv
// Round-robin arbiter between the CPU (master 0) and DMA/loader (master 1)
// with bounded bursts, a one-cycle turnaround and registered read return.
module reflet_bus_arbiter
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int wordsize  = 16,
    parameter int max_burst = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m1_req,
    input  logic [wordsize-1:0] m0_addr,
    input  logic [wordsize-1:0] m1_addr,
    input  logic [wordsize-1:0] m0_data_out,
    input  logic [wordsize-1:0] m1_data_out,
    input  logic                m0_write_en,
    input  logic                m1_write_en,
    output logic                m0_grant,
    output logic                m1_grant,
    output logic [wordsize-1:0] m0_data_in,
    output logic [wordsize-1:0] m1_data_in,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_data_out,
    output logic                bus_write_en,
    input  logic [wordsize-1:0] bus_data_in
);

    localparam logic [8:0] BURST_LIMIT = 9'(max_burst);

    arb_state_t state;
    arb_state_t state_next;
    rd_owner_t  rd_owner;
    logic       rr;
    logic       rr_next;
    logic [7:0] burst_cnt;
    logic [7:0] burst_cnt_next;
    logic       burst_done;

    // burst_cnt holds owned cycles minus one, so this is true in the last allowed cycle.
    assign burst_done = ({1'b0, burst_cnt} + 9'd1) >= BURST_LIMIT;

    always_comb begin
        state_next     = state;
        rr_next        = rr;
        burst_cnt_next = burst_cnt;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || !rr)) begin
                    state_next     = OWN0;
                    burst_cnt_next = '0;
                end else if (m1_req) begin
                    state_next     = OWN1;
                    burst_cnt_next = '0;
                end
            end
            OWN0: begin
                if (!m0_req || (m1_req && burst_done)) begin
                    rr_next    = 1'b1;
                    state_next = m1_req ? SWITCH : IDLE;
                end else begin
                    burst_cnt_next = sat_inc(burst_cnt);
                end
            end
            OWN1: begin
                if (!m1_req || (m0_req && burst_done)) begin
                    rr_next    = 1'b0;
                    state_next = m0_req ? SWITCH : IDLE;
                end else begin
                    burst_cnt_next = sat_inc(burst_cnt);
                end
            end
            SWITCH: begin
                // rr already names the master that did not own before the turnaround.
                if (rr ? m1_req : m0_req) begin
                    state_next     = rr ? OWN1 : OWN0;
                    burst_cnt_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= 1'b0;
            burst_cnt <= '0;
            m0_grant  <= 1'b0;
            m1_grant  <= 1'b0;
            rd_owner  <= NONE;
        end else begin
            state     <= state_next;
            rr        <= rr_next;
            burst_cnt <= burst_cnt_next;
            m0_grant  <= (state_next == OWN0);
            m1_grant  <= (state_next == OWN1);
            rd_owner  <= owner_of(state);
        end
    end

    // Grants are cleared asynchronously by reset, so gating on them drops writes at once.
    always_comb begin
        bus_addr     = '0;
        bus_data_out = '0;
        bus_write_en = 1'b0;
        if (m0_grant) begin
            bus_addr     = m0_addr;
            bus_data_out = m0_data_out;
            bus_write_en = m0_write_en;
        end else if (m1_grant) begin
            bus_addr     = m1_addr;
            bus_data_out = m1_data_out;
            bus_write_en = m1_write_en;
        end
    end

    always_comb begin
        m0_data_in = (rd_owner == M0) ? bus_data_in : '0;
        m1_data_in = (rd_owner == M1) ? bus_data_in : '0;
    end

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Self-checking bench for reflet_bus_arbiter: directed scenarios plus random
// traffic compared against a tenure-based behavioural model.
module tb_reflet_bus_arbiter;

    localparam int W    = 16;
    localparam int MAXB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         m0_req = 1'b0;
    logic         m1_req = 1'b0;
    logic [W-1:0] m0_addr = '0;
    logic [W-1:0] m1_addr = '0;
    logic [W-1:0] m0_data_out = '0;
    logic [W-1:0] m1_data_out = '0;
    logic         m0_write_en = 1'b0;
    logic         m1_write_en = 1'b0;
    logic [W-1:0] bus_data_in = '0;
    logic         m0_grant;
    logic         m1_grant;
    logic [W-1:0] m0_data_in;
    logic [W-1:0] m1_data_in;
    logic [W-1:0] bus_addr;
    logic [W-1:0] bus_data_out;
    logic         bus_write_en;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // Model: who holds the bus, how long they have held it, whose turn is next.
    int mOwner;
    bit mTurnaround;
    int mTenure;
    int mTurn;
    int mRdOwner;

    logic [1:0]   lastGrant;
    logic         lastWe;
    logic [W-1:0] lastAddr;
    logic [W-1:0] lastDout;
    logic [W-1:0] lastM0Din;
    logic [W-1:0] lastM1Din;

    always #5 clk = ~clk;

    reflet_bus_arbiter #(.wordsize(W), .max_burst(MAXB)) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req       (m0_req),
        .m1_req       (m1_req),
        .m0_addr      (m0_addr),
        .m1_addr      (m1_addr),
        .m0_data_out  (m0_data_out),
        .m1_data_out  (m1_data_out),
        .m0_write_en  (m0_write_en),
        .m1_write_en  (m1_write_en),
        .m0_grant     (m0_grant),
        .m1_grant     (m1_grant),
        .m0_data_in   (m0_data_in),
        .m1_data_in   (m1_data_in),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_write_en (bus_write_en),
        .bus_data_in  (bus_data_in)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d observed 0x%0h expected 0x%0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic modelReset();
        mOwner      = -1;
        mTurnaround = 1'b0;
        mTenure     = 0;
        mTurn       = 0;
        mRdOwner    = -1;
    endtask

    task automatic modelStep();
        bit r [2];
        int other;
        r[0] = m0_req;
        r[1] = m1_req;
        mRdOwner = mOwner;
        if (mTurnaround) begin
            mTurnaround = 1'b0;
            mOwner      = r[mTurn] ? mTurn : -1;
            mTenure     = 0;
        end else if (mOwner < 0) begin
            if (r[0] && r[1]) mOwner = mTurn;
            else if (r[0])    mOwner = 0;
            else if (r[1])    mOwner = 1;
            mTenure = 0;
        end else begin
            other = 1 - mOwner;
            mTenure++;
            if (!r[mOwner] || (r[other] && mTenure >= MAXB)) begin
                mTurn       = other;
                mTurnaround = r[other];
                mOwner      = -1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                                 input logic [W-1:0] a0, input logic [W-1:0] a1,
                                 input logic [W-1:0] d0, input logic [W-1:0] d1,
                                 input logic [W-1:0] bdi);
        logic [W-1:0] eAddr;
        logic [W-1:0] eData;
        logic         eWe;
        @(negedge clk);
        m0_req = r0;  m1_req = r1;
        m0_write_en = w0;  m1_write_en = w1;
        m0_addr = a0;  m1_addr = a1;
        m0_data_out = d0;  m1_data_out = d1;
        bus_data_in = bdi;
        #1;
        eAddr = '0;  eData = '0;  eWe = 1'b0;
        if (mOwner == 0) begin
            eAddr = a0;  eData = d0;  eWe = w0;
        end else if (mOwner == 1) begin
            eAddr = a1;  eData = d1;  eWe = w1;
        end
        checkOutput("m0_grant", 32'(m0_grant), 32'(mOwner == 0));
        checkOutput("m1_grant", 32'(m1_grant), 32'(mOwner == 1));
        checkOutput("bus_addr", 32'(bus_addr), 32'(eAddr));
        checkOutput("bus_data_out", 32'(bus_data_out), 32'(eData));
        checkOutput("bus_write_en", 32'(bus_write_en), 32'(eWe));
        checkOutput("m0_data_in", 32'(m0_data_in), (mRdOwner == 0) ? 32'(bdi) : 32'd0);
        checkOutput("m1_data_in", 32'(m1_data_in), (mRdOwner == 1) ? 32'(bdi) : 32'd0);
        lastGrant = {m1_grant, m0_grant};
        lastWe    = bus_write_en;
        lastAddr  = bus_addr;
        lastDout  = bus_data_out;
        lastM0Din = m0_data_in;
        lastM1Din = m1_data_in;
        @(posedge clk);
        modelStep();
        cycle++;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b1;  m1_req = 1'b1;
        m0_write_en = 1'b1;  m1_write_en = 1'b1;
        m0_addr = 16'h1357;  m1_addr = 16'h2468;
        m0_data_out = 16'hAAAA;  m1_data_out = 16'h5555;
        bus_data_in = 16'hFFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_m0_grant", 32'(m0_grant), 32'd0);
        checkOutput("rst_m1_grant", 32'(m1_grant), 32'd0);
        checkOutput("rst_bus_write_en", 32'(bus_write_en), 32'd0);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("rst_bus_data_out", 32'(bus_data_out), 32'd0);
        checkOutput("rst_m0_data_in", 32'(m0_data_in), 32'd0);
        checkOutput("rst_m1_data_in", 32'(m1_data_in), 32'd0);
        reset = 1'b0;
        m0_req = 1'b0;  m1_req = 1'b0;
        m0_write_en = 1'b0;  m1_write_en = 1'b0;
        m0_addr = '0;  m1_addr = '0;  m0_data_out = '0;  m1_data_out = '0;
        bus_data_in = '0;
        modelReset();
    endtask

    initial begin
        logic [1:0] earlyGrant [9];
        logic       earlyReq0 [9];
        $display("[TB] reflet_bus_arbiter bench start, max_burst=%0d", MAXB);
        modelReset();

        // Single master write goes through unchanged; then rr points at master 1.
        doReset();
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1, 0, 1, 0, 16'h8004, 16'h0000, 16'h1234, 16'h0000, 16'h0000);
        checkOutput("single_pre_grant", 32'(lastGrant), 32'd0);
        applyStimulus(1, 0, 1, 0, 16'h8004, 16'h0000, 16'h1234, 16'h0000, 16'h0000);
        checkOutput("single_grant", 32'(lastGrant), 32'h1);
        checkOutput("single_addr", 32'(lastAddr), 32'h8004);
        checkOutput("single_data", 32'(lastDout), 32'h1234);
        checkOutput("single_we", 32'(lastWe), 32'h1);
        applyStimulus(1, 0, 0, 0, 16'h8004, 16'h0000, 16'h1234, 16'h0000, 16'h0000);
        checkOutput("single_m1_idle", 32'(lastGrant), 32'h1);
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("rr_after_m0", 32'(lastGrant), 32'h2);

        // Continuous contention: M0 x4, SWITCH, M1 x4, SWITCH, ... with read return.
        doReset();
        for (int i = 0; i < 19; i++) begin
            int         j;
            logic [1:0] expGrant;
            applyStimulus(1, 1, 1, 1, 16'h0010, 16'h0020, 16'h1111, 16'h2222, 16'h00AB);
            if (i == 0) begin
                expGrant = 2'b00;
            end else begin
                j = (i - 1) % 10;
                expGrant = (j < 4) ? 2'b01 : (j == 4) ? 2'b00 : (j < 9) ? 2'b10 : 2'b00;
            end
            checkOutput("contention_grant", 32'(lastGrant), 32'(expGrant));
            if (expGrant == 2'b00) checkOutput("switch_we", 32'(lastWe), 32'd0);
            if (i == 5 || i == 15) begin
                checkOutput("switch_m0_rdata", 32'(lastM0Din), 32'h00AB);
                checkOutput("switch_m1_rdata", 32'(lastM1Din), 32'd0);
            end
            if (i == 10) begin
                checkOutput("switch_m1_rdata", 32'(lastM1Din), 32'h00AB);
                checkOutput("switch_m0_rdata", 32'(lastM0Din), 32'd0);
            end
        end
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("rr_after_m1", 32'(lastGrant), 32'h1);

        // Early release by M0 hands over via SWITCH; M1 then gets a full fresh burst.
        doReset();
        earlyGrant = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        earlyReq0  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(earlyReq0[i], 1, 0, 0, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0000);
            checkOutput("early_grant", 32'(lastGrant), 32'(earlyGrant[i]));
        end

        // Reset in the middle of an M1 write burst.
        doReset();
        applyStimulus(0, 1, 0, 1, 16'h0000, 16'h4000, 16'h0000, 16'hBEEF, 16'h0000);
        applyStimulus(0, 1, 0, 1, 16'h0000, 16'h4000, 16'h0000, 16'hBEEF, 16'h0000);
        checkOutput("burst_m1_grant", 32'(lastGrant), 32'h2);
        checkOutput("burst_m1_we", 32'(lastWe), 32'h1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_we", 32'(bus_write_en), 32'd0);
        checkOutput("midrst_m0_grant", 32'(m0_grant), 32'd0);
        checkOutput("midrst_m1_grant", 32'(m1_grant), 32'd0);
        m0_req = 1'b1;
        m1_req = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("post_rst_first", 32'(lastGrant), 32'h1);

        // Random traffic against the model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
